// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
endpackage

// File: rtl/mul_div_step.sv
// One iteration of shift-add multiply or restoring divide on a shared
// 2*WIDTH accumulator: {hi, multiplier} for multiply, {rem, dividend/quotient} for divide.
module mul_div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               op_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
    // Remainder shifted left with the next dividend bit pulled in.
    trial = acc_i[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, opnd_i};
    acc_o = acc_i;
    if (op_i == OP_MUL)
      acc_o = {sum, acc_i[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    else
      acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative multiply/divide with start/done handshake, one result bit per cycle.
// MULDIV_SIGNED_EN adds an sgn port for two's complement operands.
module mul_div_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULDIV_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_q, op_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [WIDTH-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               done_q;

  logic               sgn_in, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
  assign sgn_in = sgn;
`else
  assign sgn_in = 1'b0;
`endif

  // The core only sees magnitudes; most-negative maps to 2^(WIDTH-1), which still fits.
  assign a_neg = sgn_in & a[WIDTH-1];
  assign b_neg = sgn_in & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .op_i   (op_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    prod_d  = prod_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        neg_a_d = a_neg;
        neg_b_d = b_neg;
        dbz_d   = 1'b0;
        if (op == OP_DIV && b == '0) begin
          quot_d  = '1;
          rem_d   = a;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = RUN;
          if (op == OP_MUL) begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end
        end
      end
      RUN: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          state_d = DONE;
          // Sign fix-up happens on the way into the output registers.
          if (op_q == OP_MUL) begin
            prod_d = (neg_a_q ^ neg_b_q) ? (~acc_step + PW'(1)) : acc_step;
          end else begin
            quot_d = (neg_a_q ^ neg_b_q) ? (~acc_step[WIDTH-1:0] + WIDTH'(1))
                                         : acc_step[WIDTH-1:0];
            rem_d  = neg_a_q ? (~acc_step[PW-1:WIDTH] + WIDTH'(1))
                             : acc_step[PW-1:WIDTH];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      prod_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      prod_q  <= prod_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= (state_q == DONE);
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign product     = prod_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Randomised self-checking bench for mul_div_seq against an arithmetic reference model.
module tb_mul_div_seq;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           op_r = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
`ifdef MULDIV_SIGNED_EN
  logic           sgn_r = 1'b0;
`endif
  logic           busy, done, div_by_zero;
  logic [2*W-1:0] product;
  logic [W-1:0]   quotient, remainder;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_prod = '0;
  logic [W-1:0]   exp_quot = '0, exp_rem = '0;
  logic           exp_dbz = 1'b0;

  mul_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_r), .a(a), .b(b),
`ifdef MULDIV_SIGNED_EN
    .sgn(sgn_r),
`endif
    .busy(busy), .done(done), .product(product), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model: unsigned results straight from the arithmetic rules.
  task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_dbz = 1'b0;
    if (o == 1'b0) exp_prod = (2*W)'(x) * (2*W)'(y);
    else if (y == '0) begin exp_quot = '1; exp_rem = x; exp_dbz = 1'b1; end
    else begin exp_quot = x / y; exp_rem = x % y; end
  endtask

  // Issue one start pulse, scramble inputs after acceptance, wait (bounded) for done.
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output int bcnt);
    @(negedge clk); start = 1'b1; op_r = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op_r = 1'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || product !== '0 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dbz=%b p=%h q=%h r=%h, required all zero",
               busy, done, div_by_zero, product, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    int lat, bc;
    do_op(1'b0, 16'd24, 16'd2, lat, bc); model(1'b0, 16'd24, 16'd2);
    checks++; if (lat != 17) begin errors++; $display("FAIL mul_latency: got %0d, required 17", lat); end
    checks++; if (bc != 17) begin errors++; $display("FAIL mul_busy_cycles: got %0d, required 17", bc); end
    checks++; if (product !== 32'd48) begin errors++; $display("FAIL mul_24x2: got %h, required %h", product, 32'd48); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done=%b busy=%b, required 0 0", done, busy); end

    do_op(1'b1, 16'd100, 16'd7, lat, bc); model(1'b1, 16'd100, 16'd7);
    checks++; if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL div_100_7: q=%0d r=%0d dbz=%b, required 14 2 0", quotient, remainder, div_by_zero); end
    checks++; if (product !== 32'd48) begin errors++; $display("FAIL div_keeps_product: got %h, required %h", product, 32'd48); end
    checks++; if (lat != 17) begin errors++; $display("FAIL div_latency: got %0d, required 17", lat); end

    do_op(1'b0, 16'hFFFF, 16'hFFFF, lat, bc); model(1'b0, 16'hFFFF, 16'hFFFF);
    checks++; if (product !== 32'hFFFE0001) begin errors++; $display("FAIL mul_max: got %h, required FFFE0001", product); end

    do_op(1'b1, 16'd5, 16'd0, lat, bc); model(1'b1, 16'd5, 16'd0);
    checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency: got %0d, required 1", lat); end
    checks++; if (quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dbz_result: q=%h r=%0d dbz=%b, required FFFF 5 1", quotient, remainder, div_by_zero); end
    checks++; if (product !== exp_prod) begin errors++; $display("FAIL dbz_keeps_product: got %h, required %h", product, exp_prod); end

    do_op(1'b1, 16'd9, 16'd4, lat, bc); model(1'b1, 16'd9, 16'd4);
    checks++; if (div_by_zero !== 1'b0 || quotient !== 16'd2 || remainder !== 16'd1) begin
      errors++; $display("FAIL dbz_clear: dbz=%b q=%0d r=%0d, required 0 2 1", div_by_zero, quotient, remainder); end
  endtask

  task automatic test_random;
    int lat, bc;
    logic o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom);
      x = W'($urandom);
      case (i % 4)
        0: y = '0;
        1: y = W'($urandom_range(1, 3));
        default: y = W'($urandom);
      endcase
      do_op(o, x, y, lat, bc); model(o, x, y);
      checks++;
      if (lat != ((o && y == '0) ? 1 : 17)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d", i, lat); end
      checks++;
      if (product !== exp_prod || quotient !== exp_quot || remainder !== exp_rem || div_by_zero !== exp_dbz) begin
        errors++;
        $display("FAIL rand_result[%0d] op=%b a=%h b=%h: p=%h q=%h r=%h z=%b, required p=%h q=%h r=%h z=%b",
                 i, o, x, y, product, quotient, remainder, div_by_zero, exp_prod, exp_quot, exp_rem, exp_dbz);
      end
    end
  endtask

  task automatic test_ignore_start;
    int ndone;
    @(negedge clk); start = 1'b1; op_r = 1'b1; a = 16'd1000; b = 16'd33;
    @(negedge clk); start = 1'b0; op_r = 1'b0; a = 16'd3; b = 16'd3;
    model(1'b1, 16'd1000, 16'd33);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 9 || c == 14);
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_start_dones: got %0d, required 1", ndone); end
    checks++; if (quotient !== exp_quot || remainder !== exp_rem || product !== exp_prod) begin
      errors++; $display("FAIL ignore_start_result: q=%0d r=%0d p=%h, required %0d %0d %h",
                         quotient, remainder, product, exp_quot, exp_rem, exp_prod); end
  endtask

  task automatic test_abort;
    int ndone, lat, bc;
    @(negedge clk); start = 1'b1; op_r = 1'b1; a = 16'd5000; b = 16'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_prod = '0; exp_quot = '0; exp_rem = '0; exp_dbz = 1'b0;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || product !== '0 || quotient !== '0 || remainder !== '0) begin
      errors++; $display("FAIL abort_clear: busy=%b done=%b p=%h q=%h r=%h, required all zero",
                         busy, done, product, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) ndone++; end
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done: %0d active cycles, required 0", ndone); end
    do_op(1'b0, 16'd300, 16'd301, lat, bc); model(1'b0, 16'd300, 16'd301);
    checks++; if (lat != 17 || product !== exp_prod) begin
      errors++; $display("FAIL abort_restart: lat=%0d p=%h, required 17 %h", lat, product, exp_prod); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xs[3], ys[3];
    int edge_n, last, k;
    for (int i = 0; i < 3; i++) begin xs[i] = W'($urandom); ys[i] = W'($urandom); end
    @(negedge clk); start = 1'b1; op_r = 1'b0; a = xs[0]; b = ys[0];
    edge_n = 0; last = 0; k = 0;
    while (k < 3 && edge_n < 200) begin
      @(posedge clk); #1; edge_n++;
      if (done === 1'b1) begin
        model(1'b0, xs[k], ys[k]);
        checks++; if (product !== exp_prod) begin
          errors++; $display("FAIL b2b_product[%0d]: got %h, required %h", k, product, exp_prod); end
        if (k > 0) begin
          checks++; if (edge_n - last != 18) begin
            errors++; $display("FAIL b2b_spacing[%0d]: got %0d, required 18", k, edge_n - last); end
        end
        last = edge_n;
        k++;
        @(negedge clk);
        if (k < 3) begin a = xs[k]; b = ys[k]; end else start = 1'b0;
      end
    end
    start = 1'b0;
    checks++; if (k != 3) begin errors++; $display("FAIL b2b_count: got %0d dones, required 3", k); end
    repeat (20) @(posedge clk);
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed;
    int lat, bc, sx, sy;
    logic [W-1:0] x, y;
    sgn_r = 1'b1;
    do_op(1'b1, W'(-7), W'(2), lat, bc);
    checks++; if (quotient !== W'(-3) || remainder !== W'(-1) || lat != 17) begin
      errors++; $display("FAIL sdiv_-7_2: q=%h r=%h lat=%0d, required FFFD FFFF 17", quotient, remainder, lat); end
    do_op(1'b0, W'(-3), W'(4), lat, bc);
    checks++; if (product !== 32'hFFFFFFF4) begin errors++; $display("FAIL smul_-3_4: got %h, required FFFFFFF4", product); end
    do_op(1'b1, 16'h8000, 16'hFFFF, lat, bc);
    checks++; if (quotient !== 16'h8000 || remainder !== '0) begin
      errors++; $display("FAIL sdiv_min_-1: q=%h r=%h, required 8000 0000", quotient, remainder); end
    do_op(1'b1, W'(-9), 16'd0, lat, bc);
    checks++; if (quotient !== 16'hFFFF || remainder !== W'(-9) || div_by_zero !== 1'b1 || lat != 1) begin
      errors++; $display("FAIL sdiv_zero: q=%h r=%h z=%b lat=%0d", quotient, remainder, div_by_zero, lat); end
    for (int i = 0; i < 12; i++) begin
      x = W'($urandom); y = W'($urandom);
      if (y == '0) y = 16'd1;
      sx = int'($signed(x)); sy = int'($signed(y));
      do_op(1'(i), x, y, lat, bc);
      checks++;
      if (i % 2 == 0 && product !== (2*W)'(sx * sy)) begin
        errors++; $display("FAIL smul_rand[%0d]: got %h, required %h", i, product, (2*W)'(sx * sy)); end
      else if (i % 2 == 1 && (quotient !== W'(sx / sy) || remainder !== W'(sx % sy))) begin
        errors++; $display("FAIL sdiv_rand[%0d]: q=%h r=%h, required %h %h", i, quotient, remainder, W'(sx / sy), W'(sx % sy)); end
    end
    sgn_r = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_abort;
    test_back_to_back;
`ifdef MULDIV_SIGNED_EN
    test_signed;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
